// File: rtl/snake_pkg.sv
// Shared definitions for the snake core: board geometry, capacities, FSM states.
package snake_pkg;

  localparam int unsigned BOARD_WIDTH  = 20;
  localparam int unsigned BOARD_HEIGHT = 20;
  localparam int unsigned ADDR_WIDTH   = 5;
  localparam int unsigned MAX_LEN      = 32;
  localparam int unsigned PTR_WIDTH    = 5;
  localparam int unsigned LEN_WIDTH    = 6;
  localparam int unsigned INIT_LEN     = 3;

  // Direction encodings shared with snake_logic
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Body FSM states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  typedef logic [ADDR_WIDTH-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  // Starting position of segment k (0 = tail), laid out westward from board centre
  function automatic cell_t init_cell(int k, int init_len);
    cell_t c;
    c.x = ADDR_WIDTH'(int'(BOARD_WIDTH / 2) - (init_len - 1 - k));
    c.y = ADDR_WIDTH'(BOARD_HEIGHT / 2);
    return c;
  endfunction

endpackage

// File: rtl/snake_body_if.sv
// Bus between the game controller / snake_logic side and the body store.
interface snake_body_if;
  import snake_pkg::*;

  logic                  tick;
  logic [ADDR_WIDTH-1:0] next_head_x;
  logic [ADDR_WIDTH-1:0] next_head_y;
  logic [ADDR_WIDTH-1:0] food_x;
  logic [ADDR_WIDTH-1:0] food_y;
  logic [ADDR_WIDTH-1:0] query_x;
  logic [ADDR_WIDTH-1:0] query_y;
  logic [ADDR_WIDTH-1:0] head_x;
  logic [ADDR_WIDTH-1:0] head_y;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  ate;
  logic                  step_done;
  logic                  game_over;
  logic                  query_hit;

  modport master (
    output tick, next_head_x, next_head_y, food_x, food_y, query_x, query_y,
    input  head_x, head_y, length, busy, ate, step_done, game_over, query_hit
  );

  modport slave (
    input  tick, next_head_x, next_head_y, food_x, food_y, query_x, query_y,
    output head_x, head_y, length, busy, ate, step_done, game_over, query_hit
  );

endinterface

// File: rtl/snake_seg_ram.sv
// Segment ring buffer: one write port, one scan read port, parallel occupancy probe.
module snake_seg_ram import snake_pkg::*; #(
  parameter  int unsigned DEPTH = MAX_LEN,
  parameter  int unsigned INIT  = INIT_LEN,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [PW-1:0]        wr_ptr,
  input  cell_t                wr_cell,
  input  logic [PW-1:0]        rd_ptr,
  output cell_t                rd_cell_c,
  input  logic [PW-1:0]        tail_ptr,
  input  logic [LEN_WIDTH-1:0] len,
  input  cell_t                query,
  output logic                 query_hit
);

  cell_t seg [DEPTH];
  logic  hit_c;

  // Segment storage; reset lays out the initial snake from index 0 (tail)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        seg[k] <= (k < int'(INIT)) ? init_cell(k, int'(INIT)) : '0;
      end
    end else if (we) begin
      seg[wr_ptr] <= wr_cell;
    end
  end

  assign rd_cell_c = seg[rd_ptr];

  // An entry is live when its distance from the tail is below the length
  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((LEN_WIDTH'(PW'(PW'(i) - tail_ptr)) < len) && (seg[i] == query)) begin
        hit_c = 1'b1;
      end
    end
  end

  // Registered occupancy result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) query_hit <= 1'b0;
    else          query_hit <= hit_c;
  end

endmodule

// File: rtl/snake_body.sv
// Snake body: per-tick sequential self-collision scan, then grow/shift commit or game over.
module snake_body import snake_pkg::*; #(
  parameter  int unsigned MAX_LEN_P  = MAX_LEN,
  parameter  int unsigned INIT_LEN_P = INIT_LEN,
  localparam int unsigned PW         = $clog2(MAX_LEN_P)
) (
  input  logic       clk,
  input  logic       reset_n,
  snake_body_if.slave bus
);

  logic [1:0]           state, state_d;
  logic [PW-1:0]        head_ptr, head_ptr_d;
  logic [PW-1:0]        tail_ptr, tail_ptr_d;
  logic [PW-1:0]        sp, sp_d;
  logic [LEN_WIDTH-1:0] len, len_d;
  logic [LEN_WIDTH-1:0] n, n_d;
  cell_t                cand, cand_d;
  cell_t                head, head_d;
  logic                 eat, eat_d;
  logic                 ate, ate_d;
  logic                 step_done, step_done_d;
  logic                 game_over, game_over_d;
  logic                 busy, busy_d;
  logic                 we_c;
  logic [PW-1:0]        wr_ptr_c;
  cell_t                rd_cell_c;
  cell_t                next_head_c, food_c, query_c;
  logic                 query_hit;

  assign next_head_c = '{x: bus.next_head_x, y: bus.next_head_y};
  assign food_c      = '{x: bus.food_x,      y: bus.food_y};
  assign query_c     = '{x: bus.query_x,     y: bus.query_y};
  assign wr_ptr_c    = PW'(head_ptr + PW'(1));

  snake_seg_ram #(.DEPTH(MAX_LEN_P), .INIT(INIT_LEN_P)) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (we_c),
    .wr_ptr    (wr_ptr_c),
    .wr_cell   (cand),
    .rd_ptr    (sp),
    .rd_cell_c (rd_cell_c),
    .tail_ptr  (tail_ptr),
    .len       (len),
    .query     (query_c),
    .query_hit (query_hit)
  );

  // Next-state and output decode
  always_comb begin
    state_d     = state;
    head_ptr_d  = head_ptr;
    tail_ptr_d  = tail_ptr;
    sp_d        = sp;
    len_d       = len;
    n_d         = n;
    cand_d      = cand;
    head_d      = head;
    eat_d       = eat;
    ate_d       = 1'b0;
    step_done_d = 1'b0;
    game_over_d = game_over;
    we_c        = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.tick) begin
          cand_d  = next_head_c;
          eat_d   = (next_head_c == food_c);
          // Without food the tail vacates this step, so it is not scanned
          sp_d    = eat_d ? tail_ptr : PW'(tail_ptr + PW'(1));
          n_d     = eat_d ? len : LEN_WIDTH'(len - LEN_WIDTH'(1));
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rd_cell_c == cand) begin
          state_d = ST_DEAD;
        end else begin
          sp_d = PW'(sp + PW'(1));
          n_d  = LEN_WIDTH'(n - LEN_WIDTH'(1));
          if (n == LEN_WIDTH'(1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        we_c       = 1'b1;
        head_ptr_d = wr_ptr_c;
        head_d     = cand;
        if (eat && (len < LEN_WIDTH'(MAX_LEN_P))) len_d = LEN_WIDTH'(len + LEN_WIDTH'(1));
        else                                      tail_ptr_d = PW'(tail_ptr + PW'(1));
        step_done_d = 1'b1;
        ate_d       = eat;
        state_d     = ST_RUN;
      end
      ST_DEAD: begin
        game_over_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_CHECK) || (state_d == ST_COMMIT);
  end

  // State and committed-snake registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      head_ptr  <= PW'(INIT_LEN_P - 1);
      tail_ptr  <= '0;
      sp        <= '0;
      len       <= LEN_WIDTH'(INIT_LEN_P);
      n         <= '0;
      cand      <= '0;
      head      <= '{x: ADDR_WIDTH'(BOARD_WIDTH / 2), y: ADDR_WIDTH'(BOARD_HEIGHT / 2)};
      eat       <= 1'b0;
      ate       <= 1'b0;
      step_done <= 1'b0;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      head_ptr  <= head_ptr_d;
      tail_ptr  <= tail_ptr_d;
      sp        <= sp_d;
      len       <= len_d;
      n         <= n_d;
      cand      <= cand_d;
      head      <= head_d;
      eat       <= eat_d;
      ate       <= ate_d;
      step_done <= step_done_d;
      game_over <= game_over_d;
      busy      <= busy_d;
    end
  end

  assign bus.head_x    = head.x;
  assign bus.head_y    = head.y;
  assign bus.length    = len;
  assign bus.busy      = busy;
  assign bus.ate       = ate;
  assign bus.step_done = step_done;
  assign bus.game_over = game_over;
  assign bus.query_hit = query_hit;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: default build plus a MAX_LEN=4 build for saturation.
module tb_snake_body;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic sat_reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  snake_body_if bi();
  snake_body_if si();

  snake_body u_dut (.clk(clk), .reset_n(reset_n), .bus(bi.slave));
  snake_body #(.MAX_LEN_P(4), .INIT_LEN_P(3)) u_sat (.clk(clk), .reset_n(sat_reset_n), .bus(si.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_main(int x, int y);
    bi.next_head_x = ADDR_WIDTH'(x);
    bi.next_head_y = ADDR_WIDTH'(y);
    bi.tick = 1'b1;
    step();
    bi.tick = 1'b0;
  endtask

  task automatic tick_sat(int x, int y);
    si.next_head_x = ADDR_WIDTH'(x);
    si.next_head_y = ADDR_WIDTH'(y);
    si.tick = 1'b1;
    step();
    si.tick = 1'b0;
  endtask

  task automatic test_reset();
    int qx[4] = '{8, 9, 10, 11};
    logic qe[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    reset_n = 1'b0; sat_reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1; sat_reset_n = 1'b1;
    step();
    total++; if (bi.head_x !== 5'd10 || bi.head_y !== 5'd10) begin bad++; $display("FAIL reset_head: got %0d,%0d want 10,10", bi.head_x, bi.head_y); end
    total++; if (bi.length !== 6'd3) begin bad++; $display("FAIL reset_length: got %0d want 3", bi.length); end
    total++; if ({bi.busy, bi.ate, bi.step_done, bi.game_over} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {bi.busy, bi.ate, bi.step_done, bi.game_over}); end
    total++; if (si.length !== 6'd3) begin bad++; $display("FAIL reset_sat_length: got %0d want 3", si.length); end
    for (int i = 0; i < 4; i++) begin
      bi.query_x = ADDR_WIDTH'(qx[i]); bi.query_y = 5'd10;
      step();
      total++; if (bi.query_hit !== qe[i]) begin bad++; $display("FAIL reset_query_%0d_10: got %b want %b", qx[i], bi.query_hit, qe[i]); end
    end
  endtask

  task automatic test_plain_move();
    int qx[3] = '{8, 9, 11};
    logic qe[3] = '{1'b0, 1'b1, 1'b1};
    bi.food_x = 5'd0; bi.food_y = 5'd0;
    tick_main(11, 10);
    step(); step();
    total++; if (bi.step_done !== 1'b0 || bi.busy !== 1'b1) begin bad++; $display("FAIL move_t2: got done=%b busy=%b want done=0 busy=1", bi.step_done, bi.busy); end
    step();
    total++; if (bi.step_done !== 1'b1 || bi.ate !== 1'b0) begin bad++; $display("FAIL move_commit_t3: got done=%b ate=%b want done=1 ate=0", bi.step_done, bi.ate); end
    total++; if (bi.head_x !== 5'd11 || bi.head_y !== 5'd10 || bi.length !== 6'd3) begin bad++; $display("FAIL move_head: got %0d,%0d len %0d want 11,10 len 3", bi.head_x, bi.head_y, bi.length); end
    step();
    total++; if (bi.step_done !== 1'b0 || bi.busy !== 1'b0) begin bad++; $display("FAIL move_pulse_end: got done=%b busy=%b want 0 0", bi.step_done, bi.busy); end
    for (int i = 0; i < 3; i++) begin
      bi.query_x = ADDR_WIDTH'(qx[i]); bi.query_y = 5'd10;
      step();
      total++; if (bi.query_hit !== qe[i]) begin bad++; $display("FAIL move_query_%0d_10: got %b want %b", qx[i], bi.query_hit, qe[i]); end
    end
  endtask

  task automatic test_eat();
    int qx[3] = '{8, 9, 12};
    logic qe[3] = '{1'b0, 1'b1, 1'b1};
    bi.food_x = 5'd12; bi.food_y = 5'd10;
    tick_main(12, 10);
    step(); step(); step();
    total++; if (bi.step_done !== 1'b0) begin bad++; $display("FAIL eat_t3: got done=%b want 0", bi.step_done); end
    step();
    total++; if (bi.ate !== 1'b1 || bi.step_done !== 1'b1) begin bad++; $display("FAIL eat_commit_t4: got ate=%b done=%b want 1 1", bi.ate, bi.step_done); end
    total++; if (bi.length !== 6'd4 || bi.head_x !== 5'd12) begin bad++; $display("FAIL eat_len: got len %0d head_x %0d want 4 12", bi.length, bi.head_x); end
    step();
    total++; if (bi.ate !== 1'b0) begin bad++; $display("FAIL eat_pulse_end: got %b want 0", bi.ate); end
    bi.food_x = 5'd0; bi.food_y = 5'd0;
    for (int i = 0; i < 3; i++) begin
      bi.query_x = ADDR_WIDTH'(qx[i]); bi.query_y = 5'd10;
      step();
      total++; if (bi.query_hit !== qe[i]) begin bad++; $display("FAIL eat_query_%0d_10: got %b want %b", qx[i], bi.query_hit, qe[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    bi.next_head_x = 5'd13; bi.next_head_y = 5'd10;
    bi.tick = 1'b1;
    step(); step(); step();
    bi.tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bi.step_done) dones++;
      step();
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    total++; if (bi.head_x !== 5'd13 || bi.length !== 6'd4) begin bad++; $display("FAIL b2b_state: got head_x %0d len %0d want 13 4", bi.head_x, bi.length); end
  endtask

  task automatic test_grow_and_tail_chase();
    int cyc;
    bi.food_x = 5'd14; bi.food_y = 5'd10;
    tick_main(14, 10);
    cyc = 0;
    while (!bi.step_done && cyc < 40) begin step(); cyc++; end
    total++; if (bi.step_done !== 1'b1 || cyc !== 5) begin bad++; $display("FAIL grow_commit: got done=%b after %0d want done=1 after 5", bi.step_done, cyc); end
    total++; if (bi.length !== 6'd5 || bi.ate !== 1'b1) begin bad++; $display("FAIL grow_len: got len %0d ate %b want 5 1", bi.length, bi.ate); end
    step();
    bi.food_x = 5'd0; bi.food_y = 5'd0;
    tick_main(10, 10);
    cyc = 0;
    while (!bi.step_done && !bi.game_over && cyc < 40) begin step(); cyc++; end
    total++; if (bi.step_done !== 1'b1 || bi.game_over !== 1'b0 || cyc !== 5) begin bad++; $display("FAIL tail_chase: got done=%b over=%b after %0d want 1 0 after 5", bi.step_done, bi.game_over, cyc); end
    total++; if (bi.head_x !== 5'd10 || bi.length !== 6'd5) begin bad++; $display("FAIL tail_chase_state: got head_x %0d len %0d want 10 5", bi.head_x, bi.length); end
    step();
  endtask

  task automatic test_collision();
    int dones = 0;
    tick_main(12, 10);
    step();
    total++; if (bi.game_over !== 1'b0) begin bad++; $display("FAIL coll_t1: got over=%b want 0", bi.game_over); end
    step();
    total++; if (bi.game_over !== 1'b1 || bi.step_done !== 1'b0) begin bad++; $display("FAIL coll_t2: got over=%b done=%b want 1 0", bi.game_over, bi.step_done); end
    tick_main(15, 10);
    for (int i = 0; i < 8; i++) begin
      if (bi.step_done) dones++;
      step();
    end
    total++; if (dones !== 0 || bi.busy !== 1'b0) begin bad++; $display("FAIL dead_tick: got dones %0d busy %b want 0 0", dones, bi.busy); end
    total++; if (bi.head_x !== 5'd10 || bi.length !== 6'd5 || bi.game_over !== 1'b1) begin bad++; $display("FAIL dead_frozen: got head_x %0d len %0d over %b want 10 5 1", bi.head_x, bi.length, bi.game_over); end
    bi.query_x = 5'd11; bi.query_y = 5'd10;
    step();
    total++; if (bi.query_hit !== 1'b1) begin bad++; $display("FAIL dead_query_tail: got %b want 1", bi.query_hit); end
  endtask

  task automatic test_reset_mid_check();
    int dones = 0;
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    bi.food_x = 5'd0; bi.food_y = 5'd0;
    tick_main(11, 10);
    step();
    total++; if (bi.busy !== 1'b1) begin bad++; $display("FAIL midreset_busy: got %b want 1", bi.busy); end
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    total++; if (bi.busy !== 1'b0 || bi.head_x !== 5'd10 || bi.length !== 6'd3) begin bad++; $display("FAIL midreset_state: got busy %b head_x %0d len %0d want 0 10 3", bi.busy, bi.head_x, bi.length); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (bi.step_done) dones++;
    end
    total++; if (dones !== 0 || bi.head_x !== 5'd10) begin bad++; $display("FAIL midreset_no_commit: got dones %0d head_x %0d want 0 10", dones, bi.head_x); end
    bi.query_x = 5'd8; bi.query_y = 5'd10;
    step();
    total++; if (bi.query_hit !== 1'b1) begin bad++; $display("FAIL midreset_query: got %b want 1", bi.query_hit); end
  endtask

  task automatic test_saturation();
    int cyc;
    int qx[3] = '{8, 9, 12};
    logic qe[3] = '{1'b0, 1'b1, 1'b1};
    si.food_x = 5'd11; si.food_y = 5'd10;
    tick_sat(11, 10);
    cyc = 0;
    while (!si.step_done && cyc < 40) begin step(); cyc++; end
    total++; if (si.ate !== 1'b1 || si.length !== 6'd4 || cyc !== 4) begin bad++; $display("FAIL sat_grow: got ate %b len %0d after %0d want 1 4 after 4", si.ate, si.length, cyc); end
    step();
    si.food_x = 5'd12;
    tick_sat(12, 10);
    cyc = 0;
    while (!si.step_done && cyc < 40) begin step(); cyc++; end
    total++; if (si.ate !== 1'b1 || si.length !== 6'd4 || cyc !== 5) begin bad++; $display("FAIL sat_full_eat: got ate %b len %0d after %0d want 1 4 after 5", si.ate, si.length, cyc); end
    total++; if (si.head_x !== 5'd12) begin bad++; $display("FAIL sat_head: got %0d want 12", si.head_x); end
    for (int i = 0; i < 3; i++) begin
      si.query_x = ADDR_WIDTH'(qx[i]); si.query_y = 5'd10;
      step();
      total++; if (si.query_hit !== qe[i]) begin bad++; $display("FAIL sat_query_%0d_10: got %b want %b", qx[i], si.query_hit, qe[i]); end
    end
    si.food_x = 5'd9;
    tick_sat(9, 10);
    step(); step();
    total++; if (si.game_over !== 1'b1 || si.length !== 6'd4) begin bad++; $display("FAIL sat_tail_scanned: got over %b len %0d want 1 4", si.game_over, si.length); end
  endtask

  initial begin
    reset_n = 1'b0; sat_reset_n = 1'b0;
    bi.tick = 1'b0; bi.next_head_x = '0; bi.next_head_y = '0;
    bi.food_x = '0; bi.food_y = '0; bi.query_x = '0; bi.query_y = '0;
    si.tick = 1'b0; si.next_head_x = '0; si.next_head_y = '0;
    si.food_x = '0; si.food_y = '0; si.query_x = '0; si.query_y = '0;
    test_reset();
    test_plain_move();
    test_eat();
    test_back_to_back();
    test_grow_and_tail_chase();
    test_collision();
    test_reset_mid_check();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_body.md
# snake_body

Segment store and move-commit stage for the snake core; it consumes `next_head_x/next_head_y` from `snake_logic` once per game tick. On each tick it checks the candidate head against the stored body with a sequential scan, then commits the move (grow or shift) or enters game-over. It drives the current `head_x/head_y` back into `snake_logic`, and it exposes length, eat and occupancy results to the game controller and food placer.

## Interface
- `BOARD_WIDTH`, 20, columns; x range 0..19
- `BOARD_HEIGHT`, 20, rows; y range 0..19
- `ADDR_WIDTH`, 5, coordinate width
- `MAX_LEN`, 32, segment capacity; must be a power of 2
- `PTR_WIDTH`, 5, log2(MAX_LEN)
- `LEN_WIDTH`, 6, width of `length`; holds 0..MAX_LEN
- `INIT_LEN`, 3, length after reset; range 2..MAX_LEN
- `clk` in 1: the single clock
- `reset_n` in 1: asynchronous, active-low reset
- `tick` in 1: one-cycle game-step strobe
- `next_head_x`, `next_head_y` in ADDR_WIDTH: candidate head from `snake_logic`
- `food_x`, `food_y` in ADDR_WIDTH: current food cell
- `query_x`, `query_y` in ADDR_WIDTH: occupancy probe
- `head_x`, `head_y` out ADDR_WIDTH: committed head, fed to `snake_logic`
- `length` out LEN_WIDTH: committed segment count
- `busy` out 1: high while in CHECK or COMMIT
- `ate` out 1: one-cycle pulse; the committed move landed on food
- `step_done` out 1: one-cycle pulse; a move was committed
- `game_over` out 1: sticky self-collision flag
- `query_hit` out 1: registered; the probed cell is occupied

## Operation
- Storage: ring buffers `seg_x[MAX_LEN]` and `seg_y[MAX_LEN]`, plus `head_ptr` and `tail_ptr` (PTR_WIDTH bits, wrap modulo MAX_LEN).
- Reset values:
  - Segment k (k = 0..INIT_LEN-1, tail to head) is at (BOARD_WIDTH/2 - (INIT_LEN-1-k), BOARD_HEIGHT/2). The head is at (10,10), heading east.
  - `tail_ptr`=0, `head_ptr`=INIT_LEN-1, `length`=INIT_LEN, `head`=(10,10).
  - `busy`, `ate`, `step_done`, `game_over`, `query_hit` all 0. State RUN.
- FSM:
  - **RUN**: on `tick`, latch `cand`=`next_head`. Set `eat`=(cand==food). Set scan pointer `sp`=`tail_ptr` if `eat`, else `tail_ptr`+1. Set scan count `n`=`length` if `eat`, else `length`-1. Go to CHECK.
  - **CHECK**: compare `cand` against `seg[sp]`, one entry per cycle, then `sp`++ and `n`--. On a match, go to DEAD. When `n` reaches 0 with no match, go to COMMIT.
  - **COMMIT**: `head_ptr`++ and `seg[head_ptr]`=`cand`.
    - If `eat` and `length`<MAX_LEN: `length`++ and `tail_ptr` is held.
    - Otherwise: `tail_ptr`++.
    - Pulse `step_done`; pulse `ate` if `eat`. Return to RUN.
  - **DEAD**: `game_over`=1. All ticks are ignored and the segments are frozen. Only `reset_n` exits this state.
- The tail cell is excluded from the scan when not eating, because the tail vacates in the same step. Moving into the current tail cell is therefore legal.
- When `length`==MAX_LEN, eating still pulses `ate`, the tail still advances, and the tail is still included in the scan (`eat`=1).
- A `tick` while `busy` or in DEAD is dropped. It is neither queued nor counted.
- `query_hit` is registered each cycle as the OR of (query==seg[i]) over all live entries of the committed state. During CHECK the pre-commit state is reported.
- Coordinates are compared as full ADDR_WIDTH values. Wrap-around is owned upstream.

## Timing
- `tick` is sampled at edge T. Scan cycles run over edges T+1..T+n.
- The commit edge is T+n+1. `head`, `length`, `ate` and `step_done` change there. `ate` and `step_done` are high for exactly one cycle.
- A collision on scan cycle k sets `game_over` at edge T+k+1.
- Worst-case latency is MAX_LEN+1 cycles. The controller spaces ticks at least MAX_LEN+3 cycles apart, so `snake_logic` re-registers `next_head` before the next tick.
- `query_hit` has a latency of 1 cycle.
- Asserting `reset_n` low in any state restores all reset values immediately. It aborts a scan in progress without committing it.

## Structure
- The shared package `snake_pkg` holds:
  - the board dimensions, ADDR_WIDTH and the direction encodings already used by `snake_logic`
  - MAX_LEN, INIT_LEN
  - the FSM state enum (RUN, CHECK, COMMIT, DEAD)
- Sub-module `snake_seg_ram`: the ring buffer with one write port and one scan read port, plus parallel occupancy compare for the query.

## Test plan
- **Reset:** after reset, `head`=(10,10), `length`=3, cells (8,10),(9,10),(10,10) give `query_hit`=1, (11,10) gives 0, all pulses are 0.
- **Plain move:** `next_head`=(11,10), no food, tick -> commit at T+3, `head`=(11,10), `length`=3, `query_hit`(8,10)=0, `ate`=0.
- **Eat:** food=(11,10), tick -> commit at T+4, `ate` pulse, `length`=4, (8,10) still occupied.
- **Collision vs tail chase:**
  - Grow to length 5, then drive `cand` onto a mid-body cell -> `game_over`=1, later ticks are ignored.
  - Separately, `cand` equal to the tail cell without food -> legal commit.
- **Saturation:** with MAX_LEN=4, eat at length 4 -> `ate`=1, `length` stays 4, tail advances.
- **Robustness:**
  - A tick asserted while `busy` is dropped: only one `step_done` is produced.
  - `reset_n` pulsed low mid-CHECK -> reset state, no commit.
